// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types and helpers for the PWM ramp controller.
//   ctrl_state_t : controller FSM states
//   DUTY_W       : duty-cycle width
//   step_toward  : move cur toward tgt by step, clamped so it never passes tgt
package pwm_ctrl_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEAD} ctrl_state_t;

  // The arithmetic is one bit wider than the duty value so that both
  // overflow above 255 and underflow below 0 are visible. In either case the
  // result is clamped to tgt.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] tgt,
                                                    input logic [DUTY_W-1:0] step);
    logic [DUTY_W:0] s;
    s           = '0;
    step_toward = cur;
    if (cur < tgt) begin
      s           = {1'b0, cur} + {1'b0, step};
      step_toward = (s > {1'b0, tgt}) ? tgt : s[DUTY_W-1:0];
    end else if (cur > tgt) begin
      s           = {1'b0, cur} - {1'b0, step};
      step_toward = (s[DUTY_W] || (s < {1'b0, tgt})) ? tgt : s[DUTY_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: modulo-N counter of tick_i pulses.
//   clk_i  : clock
//   rst_i  : async active-high reset
//   clr_i  : synchronous clear; takes priority over tick_i
//   tick_i : count enable pulse
//   tc_o   : terminal count, high on a tick_i that arrives while the count is N-1
module tick_divider #(
  parameter int N = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic tc_o
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = tick_i && (cnt_q == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slews the PWM duty cycle toward a commanded target in fixed
// steps aligned to PWM periods. A direction reversal first brakes to zero,
// then holds the PWM disabled for a dead-time, then flips the direction.
//   clk         : clock
//   clr         : async active-high reset
//   enable      : run enable; low forces an immediate stop
//   period_tick : one-cycle pulse at each PWM period start
//   tgt_valid   : command valid; tgt_duty/tgt_dir are latched when it is high
//   tgt_ready   : always high outside reset
//   duty_cycle  : registered duty to the PWM
//   dir         : registered motor direction
//   pwm_en      : registered PWM enable
//   busy        : registered, high while the state is not IDLE
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int STEP         = 8,
  parameter int RAMP_DIV     = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              enable,
  input  logic              period_tick,
  input  logic              tgt_valid,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              tgt_dir,
  output logic              tgt_ready,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              dir,
  output logic              pwm_en,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

  ctrl_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] t_duty_q, t_duty_d;
  logic              dir_q, dir_d;
  logic              t_dir_q, t_dir_d;
  logic              busy_q, pwm_en_q;
  logic              div_clr, dead_clr, step_tc, dead_tc;

  // The ramp divider qualifies duty steps. The dead divider counts the
  // reversal dead-time and is held at zero outside DEAD, so the tick that
  // finishes BRAKE is never counted toward the dead-time.
  tick_divider #(.N(RAMP_DIV)) u_ramp_div (
    .clk_i (clk), .rst_i (clr), .clr_i (div_clr), .tick_i (period_tick), .tc_o (step_tc)
  );

  tick_divider #(.N(DEAD_PERIODS)) u_dead_div (
    .clk_i (clk), .rst_i (clr), .clr_i (dead_clr), .tick_i (period_tick), .tc_o (dead_tc)
  );

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    t_duty_d = t_duty_q;
    t_dir_d  = t_dir_q;

    // Commands are accepted even while stopped. The FSM below reads only the
    // registered target, so a command that coincides with a step cannot
    // affect that step.
    if (tgt_valid) begin
      t_duty_d = tgt_duty;
      t_dir_d  = tgt_dir;
    end

    if (!enable) begin
      state_d = IDLE;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (t_dir_q != dir_q)        state_d = (duty_q != '0) ? BRAKE : DEAD;
          else if (duty_q != t_duty_q) state_d = RAMP;
        end
        RAMP: begin
          // A reversal pending mid-ramp starts braking at once. A step that is
          // due on this cycle already moves toward zero.
          if (t_dir_q != dir_q) begin
            state_d = BRAKE;
            if (step_tc) duty_d = step_toward(duty_q, '0, STEP_V);
          end else if (duty_q == t_duty_q) begin
            state_d = IDLE;
          end else if (step_tc) begin
            duty_d = step_toward(duty_q, t_duty_q, STEP_V);
          end
        end
        BRAKE: begin
          if (duty_q == '0)  state_d = DEAD;
          else if (step_tc)  duty_d  = step_toward(duty_q, '0, STEP_V);
        end
        DEAD: begin
          // The dead-time always runs to completion. If the target direction
          // has returned to the old direction, dir simply reloads that value.
          if (dead_tc) begin
            dir_d   = t_dir_q;
            state_d = (t_duty_q == '0) ? IDLE : RAMP;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    div_clr  = !enable || (((state_q == IDLE) || (state_q == DEAD)) && (state_d != state_q));
    dead_clr = !enable || (state_q != DEAD);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      dir_q    <= 1'b0;
      t_duty_q <= '0;
      t_dir_q  <= 1'b0;
      busy_q   <= 1'b0;
      pwm_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
      t_duty_q <= t_duty_d;
      t_dir_q  <= t_dir_d;
      busy_q   <= (state_d != IDLE);
      pwm_en_q <= enable && (state_d != DEAD);
    end
  end

  assign tgt_ready  = !clr;
  assign duty_cycle = duty_q;
  assign dir        = dir_q;
  assign pwm_en     = pwm_en_q;
  assign busy       = busy_q;

endmodule
